// File: rtl/ram_lsu_ctrl.sv
// ram_lsu_ctrl: load/store front end for the word-wide data RAM.
// One request at a time. Byte and halfword stores are read-modify-write
// because the RAM has no byte enables. Sub-word loads are lane-extracted and
// sign- or zero-extended. Misaligned and illegal-size accesses are reported
// as errors without touching the RAM.
// Optional build macro RAM_BOUND_CHK_EN: when defined, a word index
// >= RAM_DEPTH is also an error. When undefined, the address goes to the RAM as-is.
module ram_lsu_ctrl #(
    parameter int RAM_DEPTH = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [31:0]       ram_wr_data_o,
    output logic [ADDR_W-1:0] ram_rd_addr_o,
    input  logic [31:0]       ram_rd_data_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef RAM_BOUND_CHK_EN
    localparam logic BOUND_CHK = 1'b1;
`else
    localparam logic BOUND_CHK = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(RAM_DEPTH);

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte/half lane of a RAM word with store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [15:0] data
    );
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'b00:   res[7:0]   = data[7:0];
                    2'b01:   res[15:8]  = data[7:0];
                    2'b10:   res[23:16] = data[7:0];
                    2'b11:   res[31:24] = data[7:0];
                    default: res = word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    state_t              r_state;
    state_t              w_state_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_we;
    logic                r_unsigned;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_ram_wr_en;
    logic [ADDR_W-1:0]   r_ram_wr_addr;
    logic [31:0]         r_ram_wr_data;

    logic                w_accept;
    logic                w_misalign;
    logic                w_oob;
    logic                w_req_err;

    assign w_accept = (r_state == ST_IDLE) && req_valid_i;
    assign w_oob    = BOUND_CHK && ({2'b00, req_addr_i[ADDR_W-1:2]} >= DEPTH_W);
    assign w_req_err = w_misalign || w_oob;

    // Alignment and size legality of the incoming request.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size_i)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = req_addr_i[0];
            SZ_WORD: w_misalign = (req_addr_i[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state sequencing for error, word store, load and RMW paths.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!req_valid_i) begin
                    w_state_n = ST_IDLE;
                end else if (w_req_err) begin
                    w_state_n = ST_RESP;
                end else if (req_we_i && (req_size_i == SZ_WORD)) begin
                    w_state_n = ST_WR;
                end else begin
                    w_state_n = ST_RD;
                end
            end
            ST_RD:   w_state_n = ST_MRG;
            ST_MRG: begin
                if (r_we) begin
                    w_state_n = ST_WR;
                end else begin
                    w_state_n = ST_RESP;
                end
            end
            ST_WR:   w_state_n = ST_RESP;
            ST_RESP: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Request capture, registered outputs and lane extract/merge datapath.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_size        <= 2'b00;
            r_we          <= 1'b0;
            r_unsigned    <= 1'b0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0000_0000;
            r_rsp_err     <= 1'b0;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_wr_data <= 32'h0000_0000;
        end else begin
            r_req_ready <= (w_state_n == ST_IDLE);
            r_rsp_valid <= (w_state_n == ST_RESP);
            r_ram_wr_en <= (w_state_n == ST_WR);
            if (w_accept) begin
                r_addr        <= req_addr_i;
                r_size        <= req_size_i;
                r_we          <= req_we_i;
                r_unsigned    <= req_unsigned_i;
                r_ram_wr_addr <= {req_addr_i[ADDR_W-1:2], 2'b00};
                // Holds the raw store data until MRG overwrites it with the merged word.
                r_ram_wr_data <= req_wdata_i;
                r_rsp_rdata   <= 32'h0000_0000;
                r_rsp_err     <= w_req_err;
            end else begin
                r_rsp_err <= 1'b0;
                if (r_state == ST_MRG) begin
                    if (r_we) begin
                        r_ram_wr_data <= store_merge(ram_rd_data_i, r_size, r_addr[1:0],
                                                     r_ram_wr_data[15:0]);
                    end else begin
                        r_rsp_rdata <= load_extract(ram_rd_data_i, r_size, r_addr[1:0],
                                                    r_unsigned);
                    end
                end
            end
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign ram_wr_en_o   = r_ram_wr_en;
    assign ram_wr_addr_o = r_ram_wr_addr;
    assign ram_wr_data_o = r_ram_wr_data;
    assign ram_rd_addr_o = r_addr;

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Directed self-checking bench for ram_lsu_ctrl with a behavioural RAM model.
module tb_ram_lsu_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              ram_wr_en_o;
    logic [ADDR_W-1:0] ram_wr_addr_o;
    logic [31:0]       ram_wr_data_o;
    logic [ADDR_W-1:0] ram_rd_addr_o;
    logic [31:0]       ram_rd_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    ram_lsu_ctrl #(.RAM_DEPTH(4096), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i)
    );

    always #5 clk = ~clk;

    // RAM model: write port, or registered read address when not writing.
    logic [31:0]       mem [0:4095];
    logic [ADDR_W-1:0] ram_rd_reg = '0;
    always @(posedge clk) begin
        if (ram_wr_en_o) mem[ram_wr_addr_o[13:2]] <= ram_wr_data_o;
        else ram_rd_reg <= ram_rd_addr_o;
    end
    assign ram_rd_data_i = mem[ram_rd_reg[13:2]];

    // Write-pulse monitor sampled mid-cycle.
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    always @(negedge clk) begin
        if (ram_wr_en_o === 1'b1) begin
            wr_count++;
            last_wr_addr = ram_wr_addr_o;
            last_wr_data = ram_wr_data_o;
        end
    end

    // Issue one request at a negedge and collect the response (bounded wait).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic one_shot);
        lat = -1; rdata = 32'hxxxx_xxxx; err = 1'bx; one_shot = 1'b0;
        for (int i = 0; i < 10 && req_ready_o !== 1'b1; i++) @(negedge clk);
        req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                lat = i; rdata = rsp_rdata_o; err = rsp_err_o;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            one_shot = (rsp_valid_o === 1'b0);
        end
    endtask

    task automatic test_reset;
        n_checks++; if ({req_ready_o, rsp_valid_o, rsp_err_o, ram_wr_en_o} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 1000", {req_ready_o, rsp_valid_o, rsp_err_o, ram_wr_en_o}); end
        n_checks++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata_o); end
        n_checks++; if (ram_wr_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_wr_addr got %h exp 0", ram_wr_addr_o); end
        n_checks++; if (ram_wr_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data got %h exp 0", ram_wr_data_o); end
        n_checks++; if (ram_rd_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_addr got %h exp 0", ram_rd_addr_o); end
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic er; logic os; int w0;
        w0 = wr_count;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, os);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d exp 2", lat); end
        n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        n_checks++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL sw_pulses got %0d exp 1", wr_count - w0); end
        n_checks++; if (last_wr_addr !== 32'h10 || last_wr_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sw_write got %h@%h exp deadbeef@00000010", last_wr_data, last_wr_addr); end
        n_checks++; if (os !== 1'b1) begin n_fail++; $display("FAIL sw_one_shot got %b exp 1", os); end
        w0 = wr_count;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, os);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h err=%b exp deadbeef err=0", rd, er); end
        n_checks++; if (wr_count !== w0) begin n_fail++; $display("FAIL lw_no_write got %0d exp 0", wr_count - w0); end
    endtask

    task automatic test_byte_rmw;
        int lat; logic [31:0] rd; logic er; logic os; int w0;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, os);
        w0 = wr_count;
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, lat, rd, er, os);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sb_latency got %0d exp 4", lat); end
        n_checks++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL sb_pulses got %0d exp 1", wr_count - w0); end
        n_checks++; if (last_wr_data !== 32'h1122AA44 || last_wr_addr !== 32'h20) begin
            n_fail++; $display("FAIL sb_merge got %h@%h exp 1122aa44@00000020", last_wr_data, last_wr_addr); end
        n_checks++; if (mem[8] !== 32'h1122AA44) begin n_fail++; $display("FAIL sb_ram got %h exp 1122aa44", mem[8]); end
    endtask

    task automatic test_extend;
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h30, 32'h30, 32'h32, 32'h32};
        logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        int lat; logic [31:0] rd; logic er; logic os;
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h8001FF80, lat, rd, er, os);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, os);
            n_checks++; if (lat !== 3 || rd !== ex[i] || er !== 1'b0) begin
                n_fail++; $display("FAIL extend_%0d got lat=%0d rdata=%h err=%b exp lat=3 rdata=%h err=0", i, lat, rd, er, ex[i]); end
        end
    endtask

    task automatic test_errors;
        logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h31, 32'h22, 32'h20, 32'h22};
        int lat; logic [31:0] rd; logic er; logic os; int w0;
        for (int i = 0; i < 4; i++) begin
            w0 = wr_count;
            do_req(we[i], sz[i], 1'b0, ad[i], 32'h12345678, lat, rd, er, os);
            n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wr_count !== w0) begin
                n_fail++; $display("FAIL error_%0d got lat=%0d err=%b rdata=%h writes=%0d exp lat=1 err=1 rdata=0 writes=0",
                                   i, lat, er, rd, wr_count - w0); end
        end
    endtask

    task automatic test_range;
        int lat; logic [31:0] rd; logic er; logic os; int w0;
        w0 = wr_count;
        do_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D, lat, rd, er, os);
`ifdef RAM_BOUND_CHK_EN
        n_checks++; if (lat !== 1 || er !== 1'b1 || wr_count !== w0) begin
            n_fail++; $display("FAIL range got lat=%0d err=%b writes=%0d exp lat=1 err=1 writes=0", lat, er, wr_count - w0); end
`else
        n_checks++; if (lat !== 2 || er !== 1'b0 || wr_count - w0 !== 1 || last_wr_addr !== 32'h4000) begin
            n_fail++; $display("FAIL range got lat=%0d err=%b writes=%0d addr=%h exp lat=2 err=0 writes=1 addr=00004000",
                               lat, er, wr_count - w0, last_wr_addr); end
`endif
    endtask

    task automatic test_reset_rmw;
        int lat; logic [31:0] rd; logic er; logic os; int w0;
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, lat, rd, er, os);
        w0 = wr_count;
        req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'h40; req_wdata_i = 32'h99; req_valid_i = 1'b1;
        @(posedge clk);            // accepted, RD
        #1 req_valid_i = 1'b0;
        @(posedge clk);            // MRG
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        n_checks++; if (ram_wr_en_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mrg got wr_en=%b ready=%b exp wr_en=0 ready=1", ram_wr_en_o, req_ready_o); end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        n_checks++; if (wr_count !== w0 || mem[16] !== 32'h55667788) begin
            n_fail++; $display("FAIL rst_no_write got writes=%0d word=%h exp writes=0 word=55667788", wr_count - w0, mem[16]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, os);
        n_checks++; if (lat !== 3 || rd !== 32'h55667788) begin
            n_fail++; $display("FAIL rst_readback got lat=%0d rdata=%h exp lat=3 rdata=55667788", lat, rd); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er; logic os;
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, lat, rd, er, os);
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", req_ready_o); end
        n_checks++; if (lat !== 4 || mem[8] !== 32'hBEEFAA44) begin
            n_fail++; $display("FAIL sh_merge got lat=%0d word=%h exp lat=4 word=beefaa44", lat, mem[8]); end
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, rd, er, os);
        n_checks++; if (lat !== 3 || rd !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL lhu_b2b got lat=%0d rdata=%h exp lat=3 rdata=0000beef", lat, rd); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = 32'h0;
        @(negedge clk); @(negedge clk);
        test_reset;
        rst_i = 1'b0;
        @(negedge clk);
        test_word;
        test_byte_rmw;
        test_extend;
        test_errors;
        test_range;
        test_reset_rmw;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
